alu_divider: RTL and testbench

- Iterative multi-cycle divider for the DIVU and DIV instructions.
- Sits beside the combinational ALU as its downstream partner for division; the execution sequencer launches it after operand fetch.
- Quotient and remainder go to the register writeback path. A divide error raises the type-0 trap request.
- Covers 8-bit (AW / byte) and 16-bit (DW:AW / word) forms, signed and unsigned, using non-restoring-free restoring division at one quotient bit per cycle.

---
 rtl/alu_divider_if.sv | 33 +++
 rtl/alu_divider.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_divider.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_divider_if
// Purpose  : Launch/result bundle between the execution sequencer and the
//            iterative divider.
// Signals  : start, signed_op, wide, dividend[31:0], divisor[15:0]  (to divider)
//            busy, done, quotient[15:0], remainder[15:0], div_error (from divider)
// Modports : master = sequencer side, slave = divider side
// Revision : 1.0 - initial release
// ============================================================================
interface alu_divider_if;
  logic        start;
  logic        signed_op;
  logic        wide;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_error;

  modport master (
    output start, signed_op, wide, dividend, divisor,
    input  busy, done, quotient, remainder, div_error
  );

  modport slave (
    input  start, signed_op, wide, dividend, divisor,
    output busy, done, quotient, remainder, div_error
  );
endinterface
`default_nettype wire

// File: rtl/alu_divider.sv
`default_nettype none
// ============================================================================
// Module   : alu_divider
// Purpose  : Iterative restoring divider for DIVU/DIV, one quotient bit per
//            cycle. Handles 16/8 (narrow) and 32/16 (wide) forms, signed and
//            unsigned. Divide-by-zero and quotient overflow set div_error.
// Ports    : clk   - core clock
//            reset - asynchronous active-high reset
//            bus   - alu_divider_if.slave (start/operands in, results out)
// Params   : EXTRA_CYCLES - idle cycles between FIX and DONE (0..15)
// Macro    : DIV_EARLY_EXIT_EN - zero dividend with nonzero divisor finishes
//            straight from PREP
// Revision : 1.0 - initial release
// ============================================================================
module alu_divider #(
  parameter int unsigned EXTRA_CYCLES = 0
) (
  input  wire logic    clk,
  input  wire logic    reset,
  alu_divider_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_PAD  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        signed_q, signed_d, wide_q, wide_d;
  logic [31:0] dividend_q, dividend_d;
  logic [15:0] divisor_q, divisor_d;
  logic        qsign_q, qsign_d, rsign_q, rsign_d;
  logic        ovf_q, ovf_d, err_q, err_d;
  logic [3:0]  cnt_q, cnt_d, pad_q, pad_d;
  logic [16:0] rem_q, rem_d;
  logic [15:0] low_q, low_d, quo_q, quo_d;
  logic [15:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic        div_error_q, div_error_d;

  // Operand conditioning and datapath helpers
  logic        dvd_neg, dvs_neg, hi_ge;
  logic [31:0] dvd_abs;
  logic [15:0] dvs_abs, dvd_hi, dvd_lo, w_mask;
  logic [16:0] rem_shift, rem_sub;
  logic [15:0] q_limit, q_signed, r_signed;

  always_comb begin
    dvd_neg = signed_q & (wide_q ? dividend_q[31] : dividend_q[15]);
    dvs_neg = signed_q & (wide_q ? divisor_q[15] : divisor_q[7]);
    if (wide_q) begin
      dvd_abs = dvd_neg ? (32'd0 - dividend_q) : dividend_q;
      dvs_abs = dvs_neg ? (16'd0 - divisor_q) : divisor_q;
      dvd_hi  = dvd_abs[31:16];
      dvd_lo  = dvd_abs[15:0];
      w_mask  = 16'hFFFF;
    end else begin
      dvd_abs = {16'd0, (dvd_neg ? (16'd0 - dividend_q[15:0]) : dividend_q[15:0])};
      dvs_abs = {8'd0, (dvs_neg ? (8'd0 - divisor_q[7:0]) : divisor_q[7:0])};
      dvd_hi  = {8'd0, dvd_abs[15:8]};
      // Narrow low half is left-aligned so the shift always feeds from bit 15
      dvd_lo  = {dvd_abs[7:0], 8'd0};
      w_mask  = 16'h00FF;
    end
    // Upper half >= divisor means the magnitude quotient needs more than W bits
    hi_ge     = (dvd_hi >= dvs_abs);
    rem_shift = {rem_q[15:0], low_q[15]};
    rem_sub   = rem_shift - {1'b0, divisor_q};
    // Largest legal magnitude: 2^(W-1) when negative, 2^(W-1)-1 when positive
    q_limit   = (wide_q ? 16'h8000 : 16'h0080) - {15'd0, ~qsign_q};
    q_signed  = (qsign_q ? (16'd0 - quo_q) : quo_q) & w_mask;
    r_signed  = (rsign_q ? (16'd0 - rem_q[15:0]) : rem_q[15:0]) & w_mask;
  end

  always_comb begin
    state_d     = state_q;
    signed_d    = signed_q;
    wide_d      = wide_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    qsign_d     = qsign_q;
    rsign_d     = rsign_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    pad_d       = pad_q;
    rem_d       = rem_q;
    low_d       = low_q;
    quo_d       = quo_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_error_d = div_error_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          signed_d   = bus.signed_op;
          wide_d     = bus.wide;
          dividend_d = bus.dividend;
          divisor_d  = bus.divisor;
          state_d    = S_PREP;
        end
      end
      S_PREP: begin
        qsign_d   = dvd_neg ^ dvs_neg;
        rsign_d   = dvd_neg;
        divisor_d = dvs_abs;
        rem_d     = {1'b0, dvd_hi};
        low_d     = dvd_lo;
        quo_d     = 16'd0;
        cnt_d     = wide_q ? 4'd15 : 4'd7;
        ovf_d     = hi_ge;
        err_d     = 1'b0;
        if (dvs_abs == 16'd0) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
`ifdef DIV_EARLY_EXIT_EN
        else if (dvd_abs == 32'd0) begin
          // rem_d/quo_d are already zero for a zero dividend
          state_d = S_DONE;
        end
`endif
        else if (!signed_q && hi_ge) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        low_d = {low_q[14:0], 1'b0};
        if (rem_shift >= {1'b0, divisor_q}) begin
          rem_d = rem_sub;
          quo_d = {quo_q[14:0], 1'b1};
        end else begin
          rem_d = rem_shift;
          quo_d = {quo_q[14:0], 1'b0};
        end
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quo_d   = q_signed;
        rem_d   = {1'b0, r_signed};
        err_d   = ovf_q | (signed_q & (quo_q > q_limit));
        pad_d   = 4'(EXTRA_CYCLES);
        state_d = (EXTRA_CYCLES == 0) ? S_DONE : S_PAD;
      end
      S_PAD: begin
        pad_d = pad_q - 4'd1;
        if (pad_q <= 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Results become visible in the DONE cycle; an error keeps the old values
    if (state_d == S_DONE && state_q != S_DONE) begin
      div_error_d = err_d;
      if (!err_d) begin
        quotient_d  = quo_d;
        remainder_d = rem_d[15:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      signed_q    <= 1'b0;
      wide_q      <= 1'b0;
      dividend_q  <= 32'd0;
      divisor_q   <= 16'd0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 4'd0;
      pad_q       <= 4'd0;
      rem_q       <= 17'd0;
      low_q       <= 16'd0;
      quo_q       <= 16'd0;
      quotient_q  <= 16'd0;
      remainder_q <= 16'd0;
      div_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      signed_q    <= signed_d;
      wide_q      <= wide_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      qsign_q     <= qsign_d;
      rsign_q     <= rsign_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      pad_q       <= pad_d;
      rem_q       <= rem_d;
      low_q       <= low_d;
      quo_q       <= quo_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_error_q <= div_error_d;
    end
  end

  assign bus.busy      = (state_q == S_PREP) || (state_q == S_ITER) ||
                         (state_q == S_FIX)  || (state_q == S_PAD);
  assign bus.done      = (state_q == S_DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_error = div_error_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_divider
// Purpose  : Self-checking bench for alu_divider. Directed vectors, control
//            scenarios and randomized operations compared against an
//            arithmetic reference model (integer / and %).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_divider;
  localparam int EXTRA = 0;

  logic clk = 1'b0;
  logic reset;

  alu_divider_if bus();

  alu_divider #(.EXTRA_CYCLES(EXTRA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q, exp_r;
  logic        exp_err;

  // Operands presented during the DONE cycle by the back-to-back scenario
  bit          nxt_s, nxt_w;
  logic [31:0] nxt_dd;
  logic [15:0] nxt_dv;

  // Reference model from the arithmetic definition of the instruction
  function automatic void model(input bit s, input bit w, input logic [31:0] dd,
                                input logic [15:0] dv, output int lat,
                                output bit err, output logic [15:0] q,
                                output logic [15:0] r);
    int     W;
    longint n, d, qq, rr, maskw, mask2;
    W     = w ? 16 : 8;
    maskw = (longint'(1) << W) - 1;
    mask2 = (longint'(1) << (2 * W)) - 1;
    n     = longint'(dd) & mask2;
    d     = longint'(dv) & maskw;
    if (s) begin
      if (n >= (longint'(1) << (2 * W - 1))) n = n - (longint'(1) << (2 * W));
      if (d >= (longint'(1) << (W - 1)))     d = d - (longint'(1) << W);
    end
    err = 1'b0;
    q   = 16'd0;
    r   = 16'd0;
    lat = W + 3 + EXTRA;
    if (d == 0) begin
      err = 1'b1;
      lat = 2;
      return;
    end
`ifdef DIV_EARLY_EXIT_EN
    if (n == 0) begin
      lat = 2;
      return;
    end
`endif
    qq = n / d;
    rr = n % d;
    if (!s) begin
      if (qq > maskw) begin
        err = 1'b1;
        lat = 2;
      end
    end else if (qq < -(longint'(1) << (W - 1)) || qq > (longint'(1) << (W - 1)) - 1) begin
      err = 1'b1;
    end
    q = 16'(qq & maskw);
    r = 16'(rr & maskw);
  endfunction

  task automatic launch(input bit s, input bit w, input logic [31:0] dd, input logic [15:0] dv);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_op = s;
    bus.wide      = w;
    bus.dividend  = dd;
    bus.divisor   = dv;
    @(posedge clk);
  endtask

  // Counts cycles from edge 0, checks busy before done, then latency/results
  task automatic wait_done(input string name, input int first_k, input int lat,
                           input bit err, input logic [15:0] q, input logic [15:0] r,
                           input bit arm);
    bit seen = 1'b0;
    for (int k = first_k; k <= lat + 4 && !seen; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        checks++;
        if (k != lat) begin
          errors++;
          $display("FAIL %s latency: got %0d want %0d", name, k, lat);
        end
        if (!err) begin
          exp_q = q;
          exp_r = r;
        end
        exp_err = err;
        checks++;
        if (bus.quotient !== exp_q || bus.remainder !== exp_r ||
            bus.div_error !== exp_err || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL %s result: got q=%h r=%h err=%b busy=%b want q=%h r=%h err=%b busy=0",
                   name, bus.quotient, bus.remainder, bus.div_error, bus.busy,
                   exp_q, exp_r, exp_err);
        end
        if (arm) begin
          bus.start     = 1'b1;
          bus.signed_op = nxt_s;
          bus.wide      = nxt_w;
          bus.dividend  = nxt_dd;
          bus.divisor   = nxt_dv;
        end
      end else if (k < lat) begin
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy cycle %0d: got %b want 1", name, k, bus.busy);
        end
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done want done at cycle %0d", name, lat);
    end else if (!arm) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.quotient !== exp_q || bus.remainder !== exp_r ||
          bus.div_error !== exp_err) begin
        errors++;
        $display("FAIL %s hold: got done=%b q=%h r=%h err=%b want done=0 q=%h r=%h err=%b",
                 name, bus.done, bus.quotient, bus.remainder, bus.div_error,
                 exp_q, exp_r, exp_err);
      end
    end
  endtask

  task automatic run_fixed(input string name, input bit s, input bit w, input logic [31:0] dd,
                           input logic [15:0] dv, input int lat, input bit err,
                           input logic [15:0] q, input logic [15:0] r);
    launch(s, w, dd, dv);
    wait_done(name, 1, lat, err, q, r, 1'b0);
  endtask

  task automatic run_model(input string name, input bit s, input bit w,
                           input logic [31:0] dd, input logic [15:0] dv);
    int lat; bit err; logic [15:0] q, r;
    model(s, w, dd, dv, lat, err, q, r);
    launch(s, w, dd, dv);
    wait_done(name, 1, lat, err, q, r, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 16'h0 ||
        bus.remainder !== 16'h0 || bus.div_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h err=%b want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_error);
    end
    reset = 1'b0;
    exp_q = 16'h0; exp_r = 16'h0; exp_err = 1'b0;
  endtask

  task automatic test_directed();
    run_fixed("divu_narrow", 1'b0, 1'b0, 32'h0000_0064, 16'h0007, 11, 1'b0, 16'h000E, 16'h0002);
    run_fixed("divu_wide",   1'b0, 1'b1, 32'h0001_0000, 16'h0003, 19, 1'b0, 16'h5555, 16'h0001);
    run_fixed("div_narrow",  1'b1, 1'b0, 32'h0000_FF9C, 16'h0007, 11, 1'b0, 16'h00F2, 16'h00FE);
    run_fixed("div_by_zero", 1'b0, 1'b0, 32'h0000_1234, 16'h0000, 2,  1'b1, 16'h0000, 16'h0000);
    run_fixed("divu_ovf",    1'b0, 1'b0, 32'h0000_0700, 16'h0007, 2,  1'b1, 16'h0000, 16'h0000);
    run_fixed("div_wide_ovf",1'b1, 1'b1, 32'h8000_0000, 16'hFFFF, 19, 1'b1, 16'h0000, 16'h0000);
    run_fixed("div_narrow_garbage_hi", 1'b1, 1'b0, 32'hDEAD_FF9C, 16'hAB07, 11, 1'b0,
              16'h00F2, 16'h00FE);
`ifdef DIV_EARLY_EXIT_EN
    run_fixed("zero_dividend", 1'b0, 1'b0, 32'h0000_0000, 16'h0005, 2, 1'b0, 16'h0000, 16'h0000);
`else
    run_fixed("zero_dividend", 1'b0, 1'b0, 32'h0000_0000, 16'h0005, 11, 1'b0, 16'h0000, 16'h0000);
`endif
  endtask

  task automatic test_ignore_start();
    int lat; bit err; logic [15:0] q, r;
    int extra_done = 0;
    model(1'b0, 1'b0, 32'h0000_00C8, 16'h0009, lat, err, q, r);
    launch(1'b0, 1'b0, 32'h0000_00C8, 16'h0009);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    @(negedge clk);  // cycle 4: second start with different operands
    bus.start    = 1'b1;
    bus.dividend = 32'h0000_0011;
    bus.divisor  = 16'h0002;
    wait_done("ignore_start", 5, lat, err, q, r, 1'b0);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done != 0) begin
      errors++;
      $display("FAIL ignore_start extra done: got %0d want 0", extra_done);
    end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    launch(1'b1, 1'b1, 32'h0012_3456, 16'h0123);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 16'h0 ||
        bus.remainder !== 16'h0 || bus.div_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h err=%b want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_error);
    end
    exp_q = 16'h0; exp_r = 16'h0; exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_mid stray activity: got %0d cycles want 0", stray);
    end
    run_model("after_reset", 1'b0, 1'b1, 32'h0012_3456, 16'h0123);
  endtask

  task automatic test_back_to_back();
    int lat; bit err; logic [15:0] q, r;
    nxt_s = 1'b1; nxt_w = 1'b1; nxt_dd = 32'hFFFF_8000; nxt_dv = 16'h0100;
    model(1'b0, 1'b1, 32'h0003_0000, 16'h0007, lat, err, q, r);
    launch(1'b0, 1'b1, 32'h0003_0000, 16'h0007);
    wait_done("b2b_first", 1, lat, err, q, r, 1'b1);
    @(posedge clk);  // start during DONE: must be ignored
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    model(nxt_s, nxt_w, nxt_dd, nxt_dv, lat, err, q, r);
    @(posedge clk);  // start still high in IDLE: this is edge 0
    wait_done("b2b_second", 1, lat, err, q, r, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bit s, w;
      logic [31:0] dd;
      logic [15:0] dv;
      int mode, W;
      s    = 1'($urandom_range(0, 1));
      w    = 1'($urandom_range(0, 1));
      dd   = $urandom;
      dv   = 16'($urandom);
      mode = $urandom_range(0, 9);
      W    = w ? 16 : 8;
      if (mode == 0) begin
        dv = w ? 16'h0 : (dv & 16'hFF00);
      end else if (mode == 1) begin
        dd = w ? 32'h0 : (dd & 32'hFFFF_0000);
      end else if (mode >= 4) begin
        dd = dd >> (W + $urandom_range(0, W));
        if (s && $urandom_range(0, 1) == 1) dd = 32'd0 - dd;
      end
      run_model("random", s, w, dd, dv);
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.wide      = 1'b0;
    bus.dividend  = 32'h0;
    bus.divisor   = 16'h0;
    reset         = 1'b1;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
